// File: rtl/digit_serial_adder_pkg.sv
// Shared types and parameter checks for the digit-serial adder/subtractor.
package digit_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic bit width_ok(input int width, input int digit);
        return (width >= 2) && (digit > 0) && (digit <= width) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder; also exposes the carry into the top bit.
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x_i,
    input  logic [DIGIT-1:0] y_i,
    input  logic             cin_i,
    output logic [DIGIT-1:0] s_o,
    output logic             cout_o,
    output logic             c_msb_in_o
);
    logic [DIGIT:0] c;

    always_comb begin
        c    = '0;
        s_o  = '0;
        c[0] = cin_i;
        for (int i = 0; i < DIGIT; i++) begin
            s_o[i]   = x_i[i] ^ y_i[i] ^ c[i];
            c[i+1]   = (x_i[i] & y_i[i]) | (c[i] & (x_i[i] ^ y_i[i]));
        end
    end

    assign cout_o     = c[DIGIT];
    assign c_msb_in_o = c[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock, LSB digit first,
// with a start/busy/done handshake and signed overflow flag.
module digit_serial_adder
    import digit_serial_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             c_in_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             c_out_o,
    output logic             overflow_o
);
    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    if (!width_ok(WIDTH, DIGIT)) begin : g_bad_param
        $error("digit_serial_adder: WIDTH must be >= 2 and divisible by DIGIT");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d, b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   sum_sh_q, sum_sh_d, sum_q, sum_d;
    logic               carry_q, carry_d, c_out_q, c_out_d, ovf_q, ovf_d;

    logic [DIGIT-1:0]   dsum;
    logic               dcout, dmsb;
    logic [WIDTH-1:0]   assembled;

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .x_i        (a_sh_q[DIGIT-1:0]),
        .y_i        (b_sh_q[DIGIT-1:0]),
        .cin_i      (carry_q),
        .s_o        (dsum),
        .cout_o     (dcout),
        .c_msb_in_o (dmsb)
    );

    // New digit enters at the MSB end, so after NDIG shifts the word is in place.
    assign assembled = (sum_sh_q >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        carry_d  = carry_q;
        sum_sh_d = sum_sh_q;
        sum_d    = sum_q;
        c_out_d  = c_out_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    // Subtract runs as a + ~b + ~borrow_in.
                    a_sh_d  = a_i;
                    b_sh_d  = sub_i ? ~b_i : b_i;
                    carry_d = sub_i ? ~c_in_i : c_in_i;
                    cnt_d   = '0;
                    state_d = RUN;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_sh_d   = a_sh_q >> DIGIT;
                b_sh_d   = b_sh_q >> DIGIT;
                carry_d  = dcout;
                sum_sh_d = assembled;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(NDIG - 1)) begin
                    sum_d   = assembled;
                    c_out_d = dcout;
                    ovf_d   = dcout ^ dmsb;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            carry_q  <= 1'b0;
            sum_sh_q <= '0;
            sum_q    <= '0;
            c_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            carry_q  <= carry_d;
            sum_sh_q <= sum_sh_d;
            sum_q    <= sum_d;
            c_out_q  <= c_out_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy_o     = (state_q == RUN);
    assign done_o     = (state_q == DONE);
    assign sum_o      = sum_q;
    assign c_out_o    = c_out_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Scoreboard bench: stimulus pushes hand-computed results, a monitor pops on done.
module tb_digit_serial_adder;
    localparam int WIDTH = 32;
    localparam int DIGIT = 4;
    localparam int NDIG  = WIDTH / DIGIT;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             c_out;
        logic             ovf;
    } exp_t;

    logic             clk_i = 1'b0;
    logic             rst_n_i = 1'b0;
    logic             start_i = 1'b0;
    logic             sub_i = 1'b0;
    logic             c_in_i = 1'b0;
    logic [WIDTH-1:0] a_i = '0;
    logic [WIDTH-1:0] b_i = '0;
    logic             busy_o, done_o, c_out_o, overflow_o;
    logic [WIDTH-1:0] sum_o;

    exp_t             sb_q[$];
    logic [WIDTH-1:0] held_sum = '0;
    int               n_vec = 0;
    int               n_err = 0;
    int               busy_cnt = 0;

    digit_serial_adder #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .start_i    (start_i),
        .sub_i      (sub_i),
        .a_i        (a_i),
        .b_i        (b_i),
        .c_in_i     (c_in_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .sum_o      (sum_o),
        .c_out_o    (c_out_o),
        .overflow_o (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: handshake invariants every cycle, result compare on done.
    always @(negedge clk_i) begin
        exp_t e;
        if (!rst_n_i) begin
            busy_cnt = 0;
        end else begin
            check("busy_done_excl", WIDTH'(busy_o & done_o), '0);
            if (busy_o) begin
                busy_cnt++;
                check("sum_hold", sum_o, held_sum);
            end
            if (done_o) begin
                check("busy_cycles", WIDTH'(busy_cnt), WIDTH'(NDIG));
                busy_cnt = 0;
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_done: sum 0x%0h with empty scoreboard", sum_o);
                end else begin
                    e = sb_q.pop_front();
                    check("sum",      sum_o,             e.sum);
                    check("c_out",    WIDTH'(c_out_o),   WIDTH'(e.c_out));
                    check("overflow", WIDTH'(overflow_o), WIDTH'(e.ovf));
                    held_sum = e.sum;
                end
            end
        end
    end

    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic s, input logic ci,
                         input logic [WIDTH-1:0] es, input logic ec, input logic eo);
        exp_t e;
        a_i = a; b_i = b; sub_i = s; c_in_i = ci; start_i = 1'b1;
        e.sum = es; e.c_out = ec; e.ovf = eo;
        sb_q.push_back(e);
        @(negedge clk_i);
        start_i = 1'b0;
        a_i = $urandom; b_i = $urandom; sub_i = 1'($urandom); c_in_i = 1'($urandom);
    endtask

    task automatic wait_done();
        int k = 0;
        while (!done_o && k < 4 * NDIG) begin
            @(negedge clk_i);
            k++;
        end
        n_vec++;
        if (!done_o) begin
            n_err++;
            $display("FAIL done_timeout: done=%0b after %0d cycles, expected 1", done_o, k);
        end
    endtask

    task automatic op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic s, input logic ci,
                      input logic [WIDTH-1:0] es, input logic ec, input logic eo);
        @(negedge clk_i);
        issue(a, b, s, ci, es, ec, eo);
        wait_done();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, WIDTH'(busy_o), '0);
        check({tag, "_done"}, WIDTH'(done_o), '0);
        check({tag, "_sum"},  sum_o,          '0);
        check({tag, "_cout"}, WIDTH'(c_out_o), '0);
        check({tag, "_ovf"},  WIDTH'(overflow_o), '0);
    endtask

    initial begin
        repeat (2) @(negedge clk_i);
        check_zero_outputs("reset");
        rst_n_i = 1'b1;

        op(32'd3,        32'd1,        1'b0, 1'b1, 32'h0000_0005, 1'b0, 1'b0);
        op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0);
        op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        op(32'd5,        32'd7,        1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
        op(32'h3F,       32'h3F,       1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        op(32'd0,        32'd0,        1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        op(32'h8000_0000, 32'd1,       1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);

        // Start during RUN is ignored; start in the done cycle is accepted.
        @(negedge clk_i);
        issue(32'h10, 32'h20, 1'b0, 1'b0, 32'h30, 1'b0, 1'b0);
        @(negedge clk_i);
        a_i = 32'h111; b_i = 32'h222; sub_i = 1'b0; c_in_i = 1'b0; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        wait_done();
        issue(32'h2, 32'h4000_0001, 1'b0, 1'b0, 32'h4000_0003, 1'b0, 1'b0);
        wait_done();
        @(negedge clk_i);
        check("idle_after_done", WIDTH'(busy_o), '0);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk_i);
        issue(32'h1234, 32'h1, 1'b0, 1'b0, 32'h1235, 1'b0, 1'b0);
        repeat (2) @(negedge clk_i);
        @(posedge clk_i);
        #2;
        sb_q.delete();
        held_sum = '0;
        rst_n_i = 1'b0;
        #1;
        check_zero_outputs("async_rst");
        @(posedge clk_i);
        #2;
        rst_n_i = 1'b1;
        @(negedge clk_i);
        check("idle_after_rst", WIDTH'(busy_o), '0);
        op(32'hAAAA_5555, 32'h5555_AAAA, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);

        repeat (3) @(negedge clk_i);
        check("scoreboard_empty", WIDTH'(sb_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/digit_serial_adder.md
Name: digit_serial_adder

Overview:
Parametrised multi-cycle adder/subtractor and the sequential successor to the combinational 32-bit full adder. It processes DIGIT bits per clock, LSB digit first, with a registered carry between digits. This trades latency for area on wide operands. It adds subtract mode, signed overflow detection and a start/busy/done handshake, and sits beside the ALU datapath for wide-operand arithmetic.

Parameters:
- WIDTH, 32: operand and result width in bits. Must be at least 2.
- DIGIT, 4: bits processed per cycle. Must divide WIDTH exactly.
- NDIG is derived as WIDTH/DIGIT and is the number of compute cycles. It is a localparam, not overridable.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a new operation; sampled on the rising edge.
- sub  in  1  0 = add (a+b+c_in); 1 = subtract (a-b-c_in).
- a  in  WIDTH  operand A; captured when start is accepted.
- b  in  WIDTH  operand B; captured when start is accepted.
- c_in  in  1  carry-in (add) or borrow-in (sub); captured when start is accepted.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; result is valid.
- sum  out  WIDTH  result; held stable from done until the next accepted start.
- c_out  out  1  carry-out of the MSB. In sub mode, 1 = no borrow.
- overflow  out  1  signed two's-complement overflow of the result.

Behaviour:
- Reset (rst_n=0, asynchronous): state goes to IDLE. busy, done, c_out, overflow and sum go to 0. The digit counter, operand shift registers and carry register go to 0. Reset takes effect in any state, including mid-operation.
- States:
  - IDLE: start=1 captures operands and goes to RUN.
  - RUN: runs for NDIG cycles, then goes to DONE.
  - DONE: start=1 captures operands and goes to RUN (back-to-back); otherwise goes to IDLE.
- Operand capture:
  - a_sh <= a.
  - b_sh <= sub ? ~b : b.
  - carry <= sub ? ~c_in : c_in.
  - cnt <= 0.
  - Subtract is therefore a + ~b + (1 - c_in).
- RUN, each cycle:
  - Low DIGIT bits of a_sh, b_sh and carry feed a DIGIT-bit ripple add.
  - The digit result shifts into sum_sh from the MSB side.
  - a_sh and b_sh shift right by DIGIT.
  - carry <= digit carry-out.
  - cnt increments.
- Final digit (cnt == NDIG-1):
  - c_out <= digit carry-out.
  - overflow <= carry into MSB XOR carry out of MSB.
  - sum <= assembled result.
  - Next state is DONE.
- Latency: start sampled at edge k produces done=1 in the cycle following edge k+NDIG. For the defaults (NDIG=8) that is 8 cycles from start to done.
- busy=1 exactly during the NDIG RUN cycles. done=1 exactly during the DONE cycle. busy and done are never both 1.
- start while busy=1 is ignored. No queuing, and operands are unaffected.
- start coincident with done is accepted. busy=1 in the next cycle; sum, c_out and overflow keep the old result until the new done.
- sum, c_out and overflow update only on the final digit, never mid-operation. Changes on a, b, sub and c_in after capture have no effect.
- Wrap-around: results are modulo 2^WIDTH; c_out carries the lost bit.
- DIGIT == WIDTH is legal: NDIG=1, one compute cycle.

Decomposition:
- Package digit_serial_adder_pkg holds:
  - the state enum {IDLE, RUN, DONE};
  - a function checking WIDTH % DIGIT == 0, used by an elaboration-time assertion.
- One natural sub-module, digit_adder: a combinational DIGIT-bit ripple adder.
  - Inputs: x, y, cin.
  - Outputs: s, cout, and c_msb_in (carry into the top bit, for overflow).
- The FSM, counter and shift registers stay in the top module.

Test Plan (WIDTH=32, DIGIT=4):
- Add 3+1 with c_in=1 -> done after 8 cycles; sum=0x00000005, c_out=0, overflow=0; busy high for exactly 8 cycles.
- Add 0xFFFFFFFF+0xFFFFFFFF with c_in=0 -> sum=0xFFFFFFFE, c_out=1, overflow=0.
- Add 0x7FFFFFFF+0x00000001 -> sum=0x80000000, c_out=0, overflow=1.
- Subtract 5-7 with c_in=0 -> sum=0xFFFFFFFE, c_out=0. Then subtract 0x3F-0x3F -> sum=0, c_out=1.
- Start pulsed again at cycle 3 of RUN with different operands -> ignored; the first result is delivered. Then start asserted in the done cycle (0x2+0x40000001) -> accepted; previous sum holds until the new done shows 0x40000003.
- Reset asserted mid-RUN (cycle 4) -> outputs are 0 immediately and asynchronously, and state is IDLE. A start after release completes normally in 8 cycles.
